mem_arbiter: RTL and testbench

Two-master arbiter that shares the single-ported system memory between the CPU and a second bus master (boot loader / debug DMA). Each master sees its own request/ready/response port. The arbiter grants one access at a time and keeps the grant while a read is outstanding. It routes the read response back to the master that issued it, and recovers from a memory that never answers by means of a timeout.

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported memory between two masters: m0 (CPU) and m1
// (boot loader / debug DMA). One access is granted per cycle. A granted read
// holds the arbiter in RD_WAIT until the memory answers or the timeout expires.
// The response is then routed to the master that issued the read.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   mN_rd_en / mN_wr_en          read / write request from master N
//   mN_addr / _wr_data / _wr_mask  request payload from master N
//   mN_ready                     request accepted this cycle (combinational)
//   mN_rd_data                   read data (the same value goes to both masters)
//   mN_rd_valid                  one-cycle read response for master N
//   mem_*                        memory-side strobes, address, data and mask
//   timeout_err                  one-cycle pulse when a read is aborted
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> on contention, the master not granted last time wins
//   undefined -> fixed priority; m0 always wins contention
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_rd_en,
  input  logic          m0_wr_en,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wr_data,
  input  logic [3:0]    m0_wr_mask,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rd_data,
  output logic          m0_rd_valid,
  input  logic          m1_rd_en,
  input  logic          m1_wr_en,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wr_data,
  input  logic [3:0]    m1_wr_mask,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rd_data,
  output logic          m1_rd_valid,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic [3:0]    mem_wr_mask,
  input  logic [DW-1:0] mem_rd_data,
  input  logic          mem_rd_valid,
  output logic          timeout_err
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_grant_q, last_grant_d;
`endif

  logic          req0, req1;
  logic          win;
  logic          win_wr;
  logic [DW-1:0] rd_data;

  assign req0 = m0_rd_en | m0_wr_en;
  assign req1 = m1_rd_en | m1_wr_en;

  // Winner selection: a lone requester always wins.
`ifdef ARB_ROUND_ROBIN_EN
  assign win = (req0 && req1) ? ~last_grant_q : ~req0;
`else
  assign win = ~req0;
`endif

  // When rd_en and wr_en are both set, the access is a write.
  assign win_wr = win ? m1_wr_en : m0_wr_en;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tmo_cnt_d   = tmo_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rd_valid = 1'b0;
    m1_rd_valid = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_mask = 4'b1111;
    rd_data     = mem_rd_data;
    timeout_err = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_rd_valid is deliberately ignored here, so a late answer after
        // a reset or timeout cannot produce a spurious response.
        if (req0 || req1) begin
          m0_ready    = ~win;
          m1_ready    = win;
          mem_wr_en   = win_wr;
          mem_rd_en   = ~win_wr;
          mem_addr    = win ? m1_addr    : m0_addr;
          mem_wr_data = win ? m1_wr_data : m0_wr_data;
          mem_wr_mask = win ? m1_wr_mask : m0_wr_mask;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = win;
`endif
          if (!win_wr) begin
            owner_d   = win;
            tmo_cnt_d = 8'd0;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // A real answer takes precedence over a timeout in the same cycle.
        if (mem_rd_valid) begin
          m0_rd_valid = ~owner_q;
          m1_rd_valid = owner_q;
          state_d     = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          m0_rd_valid = ~owner_q;
          m1_rd_valid = owner_q;
          rd_data     = '0;
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_rd_data = rd_data;
  assign m1_rd_data = rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      tmo_cnt_q <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tmo_cnt_q <= tmo_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT overridden to 8).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well before the next rising edge.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data;
  logic [3:0]    m0_wr_mask, m1_wr_mask;
  logic          m0_ready, m1_ready, m0_rd_valid, m1_rd_valid;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [3:0]    mem_wr_mask;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_valid;
  logic          timeout_err;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_wr_mask(m0_wr_mask), .m0_ready(m0_ready),
    .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_wr_mask(m1_wr_mask), .m1_ready(m1_ready),
    .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_rd_en = 0; m0_wr_en = 0; m0_addr = '0; m0_wr_data = '0; m0_wr_mask = 4'h0;
    m1_rd_en = 0; m1_wr_en = 0; m1_addr = '0; m1_wr_data = '0; m1_wr_mask = 4'h0;
    mem_rd_data = '0; mem_rd_valid = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    #1;
    compared++;
    if ({m0_ready, m1_ready, m0_rd_valid, m1_rd_valid, mem_rd_en, mem_wr_en, timeout_err} !== 7'b0) begin
      $display("FAIL reset_strobes got %b want 0000000", {m0_ready, m1_ready, m0_rd_valid, m1_rd_valid, mem_rd_en, mem_wr_en, timeout_err});
      mismatched++;
    end
    compared++;
    if (mem_addr !== 16'h0 || mem_wr_data !== 32'h0 || m0_rd_data !== 32'h0 || m1_rd_data !== 32'h0) begin
      $display("FAIL reset_data got addr=%h wdata=%h rd0=%h rd1=%h want zeros", mem_addr, mem_wr_data, m0_rd_data, m1_rd_data);
      mismatched++;
    end
    compared++;
    if (mem_wr_mask !== 4'b1111) begin
      $display("FAIL reset_mask got %b want 1111", mem_wr_mask);
      mismatched++;
    end
    tick();
    rst_n = 1;
    $display("test_reset done");
  endtask

  task automatic test_write();
    apply_reset();
    m0_wr_en = 1; m0_addr = 16'h0010; m0_wr_data = 32'hDEADBEEF; m0_wr_mask = 4'b1111;
    #1;
    compared++;
    if ({m0_ready, m1_ready, mem_wr_en, mem_rd_en} !== 4'b1010) begin
      $display("FAIL write_strobes got rdy0,rdy1,wr,rd=%b want 1010", {m0_ready, m1_ready, mem_wr_en, mem_rd_en});
      mismatched++;
    end
    compared++;
    if (mem_addr !== 16'h0010 || mem_wr_data !== 32'hDEADBEEF || mem_wr_mask !== 4'b1111) begin
      $display("FAIL write_payload got addr=%h data=%h mask=%b want 0010 deadbeef 1111", mem_addr, mem_wr_data, mem_wr_mask);
      mismatched++;
    end
    tick();
    // Still IDLE: an m1 write (with rd_en also set, so it is a write) goes straight through.
    m0_wr_en = 0;
    m1_wr_en = 1; m1_rd_en = 1; m1_addr = 16'h0020; m1_wr_data = 32'h0BADF00D; m1_wr_mask = 4'b0011;
    #1;
    compared++;
    if ({m0_ready, m1_ready, mem_wr_en, mem_rd_en} !== 4'b0110 || mem_addr !== 16'h0020 || mem_wr_mask !== 4'b0011) begin
      $display("FAIL write_next got rdy0,rdy1,wr,rd=%b addr=%h mask=%b want 0110 0020 0011", {m0_ready, m1_ready, mem_wr_en, mem_rd_en}, mem_addr, mem_wr_mask);
      mismatched++;
    end
    tick();
    clear_inputs();
    $display("test_write done");
  endtask

  task automatic test_read();
    apply_reset();
    m1_rd_en = 1; m1_addr = 16'h0100;
    #1;
    compared++;
    if ({m0_ready, m1_ready, mem_rd_en, mem_wr_en} !== 4'b0110 || mem_addr !== 16'h0100) begin
      $display("FAIL read_accept got rdy0,rdy1,rd,wr=%b addr=%h want 0110 0100", {m0_ready, m1_ready, mem_rd_en, mem_wr_en}, mem_addr);
      mismatched++;
    end
    tick();
    // RD_WAIT: m0 asks for a write and must be held off.
    m1_rd_en = 0;
    m0_wr_en = 1; m0_addr = 16'h0040; m0_wr_data = 32'h11112222; m0_wr_mask = 4'b1111;
    #1;
    compared++;
    if ({m0_ready, m1_ready, mem_rd_en, mem_wr_en, m0_rd_valid, m1_rd_valid} !== 6'b0) begin
      $display("FAIL read_wait got rdy0,rdy1,rd,wr,v0,v1=%b want 000000", {m0_ready, m1_ready, mem_rd_en, mem_wr_en, m0_rd_valid, m1_rd_valid});
      mismatched++;
    end
    tick();
    mem_rd_valid = 1; mem_rd_data = 32'h12345678;
    #1;
    compared++;
    if ({m0_ready, m1_ready, m0_rd_valid, m1_rd_valid, timeout_err} !== 5'b00010 || m1_rd_data !== 32'h12345678) begin
      $display("FAIL read_resp got rdy0,rdy1,v0,v1,tmo=%b data=%h want 00010 12345678", {m0_ready, m1_ready, m0_rd_valid, m1_rd_valid, timeout_err}, m1_rd_data);
      mismatched++;
    end
    tick();
    mem_rd_valid = 0;
    #1;
    compared++;
    if ({m0_ready, m1_rd_valid, mem_wr_en} !== 3'b101 || mem_addr !== 16'h0040) begin
      $display("FAIL read_after got rdy0,v1,wr=%b addr=%h want 101 0040", {m0_ready, m1_rd_valid, mem_wr_en}, mem_addr);
      mismatched++;
    end
    tick();
    clear_inputs();
    $display("test_read done");
  endtask

  task automatic test_contention();
    logic [3:0] exp_g1;
    apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_g1 = 4'b1010;  // cycle i uses bit i: m0, m1, m0, m1
`else
    exp_g1 = 4'b0000;  // m0 every cycle
`endif
    m0_wr_en = 1; m0_addr = 16'h0A00; m0_wr_data = 32'hAAAA0000; m0_wr_mask = 4'b1111;
    m1_wr_en = 1; m1_addr = 16'h0B00; m1_wr_data = 32'hBBBB0000; m1_wr_mask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++;
      if (m1_ready !== exp_g1[i] || m0_ready !== ~exp_g1[i] || mem_wr_en !== 1'b1) begin
        $display("FAIL contention_grant cycle=%0d got rdy0=%b rdy1=%b wr=%b want rdy1=%b", i, m0_ready, m1_ready, mem_wr_en, exp_g1[i]);
        mismatched++;
      end
      compared++;
      if (mem_wr_data !== (exp_g1[i] ? 32'hBBBB0000 : 32'hAAAA0000)) begin
        $display("FAIL contention_data cycle=%0d got %h want %h", i, mem_wr_data, exp_g1[i] ? 32'hBBBB0000 : 32'hAAAA0000);
        mismatched++;
      end
      $display("contention cycle %0d: rdy0=%b rdy1=%b", i, m0_ready, m1_ready);
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    m0_rd_en = 1; m0_addr = 16'h0300;
    mem_rd_data = 32'hA5A5A5A5;
    #1;
    compared++;
    if (m0_ready !== 1'b1 || mem_rd_en !== 1'b1) begin
      $display("FAIL tmo_accept got rdy0=%b rd=%b want 1 1", m0_ready, mem_rd_en);
      mismatched++;
    end
    tick();
    m0_rd_en = 0;
    m1_wr_en = 1; m1_addr = 16'h0310; m1_wr_data = 32'h5; m1_wr_mask = 4'b0001;
    for (int k = 1; k < 8; k++) begin
      #1;
      compared++;
      if ({m0_rd_valid, m1_rd_valid, timeout_err, m1_ready} !== 4'b0) begin
        $display("FAIL tmo_wait k=%0d got v0,v1,tmo,rdy1=%b want 0000", k, {m0_rd_valid, m1_rd_valid, timeout_err, m1_ready});
        mismatched++;
      end
      tick();
    end
    #1;
    compared++;
    if ({m0_rd_valid, m1_rd_valid, timeout_err, m1_ready} !== 4'b1010 || m0_rd_data !== 32'h0) begin
      $display("FAIL tmo_fire got v0,v1,tmo,rdy1=%b data=%h want 1010 00000000", {m0_rd_valid, m1_rd_valid, timeout_err, m1_ready}, m0_rd_data);
      mismatched++;
    end
    tick();
    #1;
    compared++;
    if ({m1_ready, timeout_err, m0_rd_valid, mem_wr_en} !== 4'b1001 || m0_rd_data !== 32'hA5A5A5A5) begin
      $display("FAIL tmo_next got rdy1,tmo,v0,wr=%b rd_data=%h want 1001 a5a5a5a5", {m1_ready, timeout_err, m0_rd_valid, mem_wr_en}, m0_rd_data);
      mismatched++;
    end
    tick();
    clear_inputs();
    $display("test_timeout done");
  endtask

  task automatic test_valid_at_timeout();
    apply_reset();
    m0_rd_en = 1; m0_addr = 16'h0400;
    tick();
    m0_rd_en = 0;
    for (int k = 1; k < 8; k++) tick();
    mem_rd_valid = 1; mem_rd_data = 32'hCAFE0001;
    #1;
    compared++;
    if ({m0_rd_valid, timeout_err} !== 2'b10 || m0_rd_data !== 32'hCAFE0001) begin
      $display("FAIL valid_wins got v0,tmo=%b data=%h want 10 cafe0001", {m0_rd_valid, timeout_err}, m0_rd_data);
      mismatched++;
    end
    tick();
    clear_inputs();
    $display("test_valid_at_timeout done");
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    m0_rd_en = 1; m0_addr = 16'h0500;
    tick();
    m0_rd_en = 0;
    #1;
    rst_n = 0;
    #1;
    compared++;
    if ({m0_ready, m1_ready, m0_rd_valid, m1_rd_valid, timeout_err} !== 5'b0) begin
      $display("FAIL rst_wait_low got %b want 00000", {m0_ready, m1_ready, m0_rd_valid, m1_rd_valid, timeout_err});
      mismatched++;
    end
    tick();
    tick();
    rst_n = 1;
    tick();
    mem_rd_valid = 1; mem_rd_data = 32'h77777777;
    #1;
    compared++;
    if ({m0_ready, m1_ready, m0_rd_valid, m1_rd_valid, timeout_err} !== 5'b0) begin
      $display("FAIL rst_late_valid got rdy0,rdy1,v0,v1,tmo=%b want 00000", {m0_ready, m1_ready, m0_rd_valid, m1_rd_valid, timeout_err});
      mismatched++;
    end
    tick();
    mem_rd_valid = 0;
    m1_rd_en = 1; m1_addr = 16'h0600;
    #1;
    compared++;
    if ({m1_ready, mem_rd_en} !== 2'b11 || mem_addr !== 16'h0600) begin
      $display("FAIL rst_then_grant got rdy1,rd=%b addr=%h want 11 0600", {m1_ready, mem_rd_en}, mem_addr);
      mismatched++;
    end
    tick();
    clear_inputs();
    $display("test_reset_in_wait done");
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_timeout();
    test_valid_at_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
